// File: rtl/boot_loader.sv
// Loads a framed symbol stream (4-symbol length, L data, XOR checksum) into program memory and holds the CPU in reset until verified.
// Latency: write outputs are registered one cycle after accept; cpu_rst_n rises on the edge that accepts a matching checksum.
// Backpressure: in_ready is high while a frame can be taken and drops for good in DONE/ERR; gaps in in_valid simply hold state.
module boot_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HDR_SYMS = (ADDR_W + DATA_W - 1) / DATA_W;
    localparam int CNT_W    = (HDR_SYMS > 1) ? $clog2(HDR_SYMS) : 1;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] xor_acc;
    logic [ADDR_W-1:0] len_shift;
    logic              accept;

    // Length arrives MSB symbol first, so shift left by one symbol per accept.
    assign len_shift = {len[ADDR_W-DATA_W-1:0], in_data};
    assign in_ready  = rst_n && (state == HDR || state == DATA || state == CHK);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HDR;
            hdr_cnt   <= '0;
            len       <= '0;
            wr_ptr    <= '0;
            xor_acc   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        busy    <= 1'b1;
                        len     <= len_shift;
                        hdr_cnt <= hdr_cnt + CNT_W'(1);
                        if (hdr_cnt == CNT_W'(HDR_SYMS - 1)) begin
                            state <= (len_shift != '0) ? DATA : CHK;
                        end
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= in_data;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        xor_acc   <= xor_acc ^ in_data;
                        if (wr_ptr == len - ADDR_W'(1)) begin
                            state <= CHK;
                        end
                    end
                    CHK: begin
                        busy <= 1'b0;
                        if (in_data == xor_acc) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
